// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between the core (port 0)
// and a second requester (port 1). Round-robin on ties, zero-latency grant,
// one-cycle read return routed to the winner, plus a memory-mapped LED
// register that snoops granted writes.
module mem_arbiter #(
    parameter int             AW       = 16,
    parameter int             DW       = 32,
    parameter logic [AW-1:0]  LED_ADDR = 16'h000F,
    parameter int             LED_W    = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m0_gnt,
    output logic             m1_gnt,
    output logic             m0_rvalid,
    output logic             m1_rvalid,
    output logic [DW-1:0]    m0_rdata,
    output logic [DW-1:0]    m1_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [LED_W-1:0] led
);

    logic             r_prio;     // port that wins a tie
    logic             r_pend_v;   // a read was granted last cycle
    logic             r_pend_id;  // which port owns that read
    logic [LED_W-1:0] r_led;

    logic             w_any;
    logic             w_win1;
    logic             w_we;
    logic             w_led_hit;

    // Port 1 wins when it is alone or when both request and it holds priority.
    always_comb begin
        w_any     = m0_req | m1_req;
        w_win1    = m1_req & (~m0_req | r_prio);
        w_we      = w_win1 ? m1_we : (m0_req & m0_we);
        w_led_hit = w_we && (mem_addr == LED_ADDR);
    end

    // Steer the winner onto the memory bus; port 0 fields when idle (don't-care).
    always_comb begin
        m0_gnt    = m0_req & ~w_win1;
        m1_gnt    = w_win1;
        mem_addr  = w_win1 ? m1_addr  : m0_addr;
        mem_wdata = w_win1 ? m1_wdata : m0_wdata;
        mem_we    = w_we;
    end

    // Round-robin priority: after a grant the loser of this cycle gets the tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_prio <= 1'b0;
        else if (w_any)
            r_prio <= ~w_win1;
    end

    // Track the one outstanding read so its data returns to the right port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend_v  <= 1'b0;
            r_pend_id <= 1'b0;
        end else begin
            r_pend_v  <= w_any & ~w_we;
            r_pend_id <= w_win1;
        end
    end

    // Capture granted writes to the LED word; memory is written as well.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_led <= '0;
        else if (w_led_hit)
            r_led <= mem_wdata[LED_W-1:0];
    end

    // Read data is broadcast; rvalid tells each port whether it is theirs.
    always_comb begin
        m0_rvalid = r_pend_v & ~r_pend_id;
        m1_rvalid = r_pend_v &  r_pend_id;
        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
        led       = r_led;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural one-cycle memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [9:0]  led;

    int checks = 0;
    int failures = 0;

    // behavioural memory: unwritten words read as A000_00xx
    logic [31:0]  mem [0:255];
    logic [255:0] wr_flag = '0;
    int           wr_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            wr_flag[mem_addr[7:0]] <= 1'b1;
            wr_count               <= wr_count + 1;
        end
        mem_rdata <= wr_flag[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                            : {24'hA00000, mem_addr[7:0]};
    end

    mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .led(led)
    );

    task automatic idle_ports();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_ports();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
        end
        checks++;
        if (led !== 10'h000) begin
            failures++;
            $display("FAIL reset_led got=%h want=000", led);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_contention();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_gnt cycle=%0d got=%b want=%b", i, {m0_gnt, m1_gnt},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            @(posedge clk); #1;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_rvalid cycle=%0d got=%b want=%b", i, {m0_rvalid, m1_rvalid},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if (m0_rdata !== ((i % 2 == 0) ? 32'hA0000010 : 32'hA0000020)) begin
                failures++;
                $display("FAIL contention_rdata cycle=%0d got=%h want=%h", i, m0_rdata,
                         (i % 2 == 0) ? 32'hA0000010 : 32'hA0000020);
            end
            @(negedge clk);
        end
        idle_ports();
    endtask

    task automatic test_held_request();
        int wc0;
        wc0 = wr_count;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030; m0_wdata = 32'h11111111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0031; m1_wdata = 32'h22222222;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, mem_addr} !== {3'b101, 16'h0030}) begin
            failures++;
            $display("FAIL held_first got=%b%b%b addr=%h want=101 addr=0030", m0_gnt, m1_gnt, mem_we, mem_addr);
        end
        @(negedge clk);
        m0_req = 1'b0; m0_we = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 16'h0031, 32'h22222222}) begin
            failures++;
            $display("FAIL held_second got=%b%b%b addr=%h data=%h want=011 addr=0031 data=22222222",
                     m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        idle_ports();
        @(posedge clk); #1;
        checks++;
        if (wr_count - wc0 !== 2) begin
            failures++;
            $display("FAIL held_write_count got=%0d want=2", wr_count - wc0);
        end
        checks++;
        if (mem[8'h30] !== 32'h11111111 || mem[8'h31] !== 32'h22222222) begin
            failures++;
            $display("FAIL held_mem_contents got=%h/%h want=11111111/22222222", mem[8'h30], mem[8'h31]);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0004; m0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b101) begin
            failures++;
            $display("FAIL wr_grant got=%b want=101", {m0_gnt, m1_gnt, mem_we});
        end
        @(negedge clk);
        m0_we = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, mem_we} !== 2'b10) begin
            failures++;
            $display("FAIL rd_grant got=%b want=10", {m0_gnt, mem_we});
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL rd_return rvalid=%b data=%h want=10 DEADBEEF", {m0_rvalid, m1_rvalid}, m0_rdata);
        end
        @(negedge clk);
        idle_ports();
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL rd_single_pulse got=%b want=00", {m0_rvalid, m1_rvalid});
        end
    endtask

    task automatic test_led();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h000F; m1_wdata = 32'h000003A5;
        @(posedge clk); #1;
        checks++;
        if (led !== 10'h3A5) begin
            failures++;
            $display("FAIL led_write got=%h want=3a5", led);
        end
        @(negedge clk);
        m1_we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h000003A5}) begin
            failures++;
            $display("FAIL led_readback rvalid=%b data=%h want=1 000003a5", m1_rvalid, m1_rdata);
        end
        @(negedge clk);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h000E; m0_wdata = 32'h00000155;
        @(posedge clk); #1;
        checks++;
        if (led !== 10'h3A5) begin
            failures++;
            $display("FAIL led_neighbour got=%h want=3a5", led);
        end
        @(negedge clk);
        idle_ports();
    endtask

    // prio is 1 on entry (last grant went to port 0)
    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid} !== 5'b00000) begin
                failures++;
                $display("FAIL idle cycle=%0d got=%b want=00000", i,
                         {m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid});
            end
        end
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL idle_prio_hold got=%b want=01", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle_ports();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        @(posedge clk); #1;
        idle_ports();
        resetn = 1'b0;
        #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, led} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid rvalid=%b led=%h want=00 000", {m0_rvalid, m1_rvalid}, led);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 16'h0020;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_prio got=%b want=10", {m0_gnt, m1_gnt});
        end
        @(negedge clk);
        idle_ports();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_held_request();
        test_write_read();
        test_led();
        test_idle();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
